// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and helpers for the multi-lane MAC pipeline.
//   BW       default activation/weight width per lane
//   PSUM_BW  default partial-sum / result width
//   LANES    default number of multiply lanes summed per beat
//   prod_width(bw)  width of one signed lane product (activation widened by one bit)
//   lane_lo(k, w)   low bit index of lane k in a packed vector of w-bit lanes
package mac_pkg;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int LANES   = 4;

  function automatic int prod_width(input int bw);
    return 2 * bw + 1;
  endfunction

  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// mac_lane_mult: combinational single-lane multiply.
//   a        bw-bit activation (signedness chosen by a_signed)
//   a_signed 1 = a is two's complement, 0 = a is unsigned
//   w        bw-bit two's complement weight
//   prod     (2*bw+1)-bit two's complement product
module mac_lane_mult
  import mac_pkg::*;
#(
  parameter int bw = BW
) (
  input  logic [bw-1:0] a,
  input  logic          a_signed,
  input  logic [bw-1:0] w,
  output logic [2*bw:0] prod
);

  localparam int pw = prod_width(bw);

  logic [pw-1:0] a_x;
  logic [pw-1:0] w_x;

  // Both operands are widened to the full product width with their own
  // extension rule; the low pw bits of the unsigned product are then the
  // exact two's complement product, since it always fits in pw bits.
  always_comb begin
    a_x  = {{(bw + 1){a_signed & a[bw-1]}}, a};
    w_x  = {{(bw + 1){w[bw-1]}}, w};
    prod = a_x * w_x;
  end

endmodule

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: two-stage pipelined multi-lane dot-product MAC.
//   clk, reset          clock, synchronous active-high reset
//   w_load, w_in        load stationary weights (lane k at [k*bw +: bw])
//   in_valid, in_ready  input beat handshake
//   a_in, a_signed      activations and their signedness for this beat
//   c_in                external partial sum (two's complement)
//   acc_mode, acc_first addend select: c_in, zero, or internal accumulator
//   out_valid, out_ready, out  result handshake and value
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds valid and its payload until that edge; ready may depend
// combinationally on the downstream ready. out/out_valid do not change while
// out_valid && !out_ready.
module mac_dot_pipe
  import mac_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int lanes   = LANES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_load,
  input  logic [lanes*bw-1:0]   w_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [lanes*bw-1:0]   a_in,
  input  logic                  a_signed,
  input  logic [psum_bw-1:0]    c_in,
  input  logic                  acc_mode,
  input  logic                  acc_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [psum_bw-1:0]    out
);

  localparam int pw = prod_width(bw);

  logic [lanes*bw-1:0] w_q, w_d;
  logic [lanes*pw-1:0] prod_c, prod_q, prod_d;
  logic [psum_bw-1:0]  s1_c_q, s1_c_d;
  logic                s1_acc_mode_q, s1_acc_mode_d;
  logic                s1_acc_first_q, s1_acc_first_d;
  logic                s1_valid_q, s1_valid_d;
  logic [psum_bw-1:0]  out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [psum_bw-1:0]  acc_q, acc_d;
  logic [psum_bw-1:0]  addend_c;
  logic [psum_bw-1:0]  sum_c;
  logic                s1_adv;
  logic                accept;

  // Lane multipliers always see the registered weights, so a beat accepted
  // on the same edge as w_load still uses the old weights.
  for (genvar k = 0; k < lanes; k++) begin : g_lane
    mac_lane_mult #(.bw(bw)) u_lane (
      .a        (a_in[lane_lo(k, bw) +: bw]),
      .a_signed (a_signed),
      .w        (w_q[lane_lo(k, bw) +: bw]),
      .prod     (prod_c[lane_lo(k, pw) +: pw])
    );
  end

  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    w_d = w_load ? w_in : w_q;
  end

  // Stage 1: capture lane products and sideband on acceptance; drain when
  // the beat moves on to stage 2 and nothing new arrives.
  always_comb begin
    s1_valid_d     = s1_valid_q;
    prod_d         = prod_q;
    s1_c_d         = s1_c_q;
    s1_acc_mode_d  = s1_acc_mode_q;
    s1_acc_first_d = s1_acc_first_q;
    if (accept) begin
      s1_valid_d     = 1'b1;
      prod_d         = prod_c;
      s1_c_d         = c_in;
      s1_acc_mode_d  = acc_mode;
      s1_acc_first_d = acc_first;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 adder: addend is read straight from acc_q so back-to-back
  // accumulate beats see the previous beat's result without a bubble.
  always_comb begin
    if (!s1_acc_mode_q) begin
      addend_c = s1_c_q;
    end else if (s1_acc_first_q) begin
      addend_c = '0;
    end else begin
      addend_c = acc_q;
    end
    sum_c = addend_c;
    for (int k = 0; k < lanes; k++) begin
      sum_c = sum_c + psum_bw'($signed(prod_q[lane_lo(k, pw) +: pw]));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    acc_d       = acc_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = sum_c;
        if (s1_acc_mode_q) begin
          acc_d = sum_c;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q            <= '0;
      prod_q         <= '0;
      s1_c_q         <= '0;
      s1_acc_mode_q  <= 1'b0;
      s1_acc_first_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      acc_q          <= '0;
    end else begin
      w_q            <= w_d;
      prod_q         <= prod_d;
      s1_c_q         <= s1_c_d;
      s1_acc_mode_q  <= s1_acc_mode_d;
      s1_acc_first_q <= s1_acc_first_d;
      s1_valid_q     <= s1_valid_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      acc_q          <= acc_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb_mac_dot_pipe: directed and randomized bench for mac_dot_pipe
// (lanes=4, bw=4, psum_bw=16). Inputs change 1 time unit after the rising
// edge; the monitor samples everything on the falling edge.
module tb_mac_dot_pipe;

  logic        clk;
  logic        reset;
  logic        w_load;
  logic [15:0] w_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic        a_signed;
  logic [15:0] c_in;
  logic        acc_mode;
  logic        acc_first;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [15:0] exp_q[$];
  int          t_q[$];
  logic [15:0] log_q[$];
  logic [15:0] m_w = '0;
  logic [15:0] m_acc = '0;
  logic [15:0] last_out = '0;
  int          cyc = 0;
  logic        armed = 1'b0;
  logic        saw_block = 1'b0;

  mac_dot_pipe #(.bw(4), .psum_bw(16), .lanes(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_load    (w_load),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .a_signed  (a_signed),
    .c_in      (c_in),
    .acc_mode  (acc_mode),
    .acc_first (acc_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_log(input string name, input int n, input logic [15:0] e [8]);
    logic [15:0] g;
    check({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = (i < log_q.size()) ? log_q[i] : 16'hxxxx;
      check(name, 32'(g), 32'(e[i]));
    end
  endtask

  // Dot product from the lane rules: activation unsigned or signed 4-bit,
  // weight signed 4-bit, plain integer arithmetic.
  function automatic int dot(input logic [15:0] a, input logic [15:0] w, input logic sgn);
    int s;
    int av;
    int wv;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      av = int'(a[4*k +: 4]);
      wv = int'(w[4*k +: 4]);
      if (sgn && av >= 8) av = av - 16;
      if (wv >= 8) wv = wv - 16;
      s = s + av * wv;
    end
    return s;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic        exp_ov;
    logic        exp_ir;
    logic [15:0] addend;
    logic [15:0] res;
    if (reset) begin
      exp_q.delete();
      t_q.delete();
      m_w      = '0;
      m_acc    = '0;
      last_out = '0;
      armed    = 1'b1;
    end else if (armed) begin
      // oldest beat is visible exactly two edges after its acceptance;
      // two beats in flight with a stalled output means no room
      exp_ov = (exp_q.size() > 0) && (cyc - t_q[0] >= 2);
      exp_ir = !((exp_q.size() == 2) && !out_ready);
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      if (exp_ov) begin
        check("out", 32'(out), 32'(exp_q[0]));
        last_out = exp_q[0];
        if (out_ready) begin
          log_q.push_back(out);
          void'(exp_q.pop_front());
          void'(t_q.pop_front());
        end
      end else begin
        check("out_hold", 32'(out), 32'(last_out));
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && exp_ir) begin
        if (!acc_mode)      addend = c_in;
        else if (acc_first) addend = '0;
        else                addend = m_acc;
        res = 16'(dot(a_in, m_w, a_signed) + int'(addend));
        if (acc_mode) m_acc = res;
        exp_q.push_back(res);
        t_q.push_back(cyc);
      end
      if (w_load) m_w = w_in;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [15:0] w);
    w_load = 1'b1;
    w_in   = w;
    tick();
    w_load = 1'b0;
  endtask

  // Presents a beat and returns 1 unit after the edge that accepted it,
  // leaving in_valid high so beats can follow back to back.
  task automatic send(input logic [15:0] a, input logic sg, input logic [15:0] c,
                      input logic am, input logic af);
    logic got;
    int   waited;
    waited    = 0;
    in_valid  = 1'b1;
    a_in      = a;
    a_signed  = sg;
    c_in      = c;
    acc_mode  = am;
    acc_first = af;
    forever begin
      @(negedge clk);
      got = in_ready;
      tick();
      if (got) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", 32'(0), 32'(1));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Counts falling edges until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 20) begin
        check("wait_out_timeout", 32'(0), 32'(1));
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [15:0] e [8];
    reset = 1'b1; w_load = 1'b0; w_in = '0; in_valid = 1'b0; a_in = '0;
    a_signed = 1'b0; c_in = '0; acc_mode = 1'b0; acc_first = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out", 32'(out), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    tick();

    // unsigned, external psum: -15+2+6-24+100 = 69, latency 2
    load_w(16'hF238);
    send(16'hF123, 1'b0, 16'd100, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("t2_latency", 32'(lat), 32'(2));
    check("t2_out", 32'(out), 32'h0045);
    idle(2);

    // signed activations: 1+2+6-24 = -15
    send(16'hF123, 1'b1, 16'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("t3_out", 32'(out), 32'hFFF1);
    idle(2);

    // accumulation chain, then restart
    load_w(16'h1111);
    log_q.delete();
    send(16'h1111, 1'b0, 16'd0, 1'b1, 1'b1);
    send(16'h1111, 1'b0, 16'd0, 1'b1, 1'b0);
    send(16'h1111, 1'b0, 16'd0, 1'b1, 1'b0);
    send(16'h1111, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(5);
    e = '{16'd4, 16'd8, 16'd12, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    check_log("t4_acc", 4, e);

    // non-accumulating beat in between leaves the accumulator alone
    log_q.delete();
    send(16'h1111, 1'b0, 16'd0, 1'b1, 1'b1);
    send(16'h1111, 1'b0, 16'd0, 1'b0, 1'b0);
    send(16'h1111, 1'b0, 16'd0, 1'b1, 1'b0);
    idle(5);
    e = '{16'd4, 16'd4, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    check_log("t4_mix", 3, e);

    // backpressure: zero weights, output stalled for 4 cycles
    load_w(16'h0000);
    log_q.delete();
    saw_block = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        repeat (4) tick();
        out_ready = 1'b1;
      end
      begin
        for (int c = 1; c <= 6; c++) send(16'h0000, 1'b0, 16'(c), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
    join
    idle(6);
    check("t5_in_ready_dropped", 32'(saw_block), 32'(1));
    e = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0};
    check_log("t5_order", 6, e);

    // wrap: 0x7FFF + 4
    load_w(16'h1111);
    send(16'h1111, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    check("t6_wrap", 32'(out), 32'h8003);
    idle(2);

    // weight switch in the same cycle as a beat
    log_q.delete();
    w_load = 1'b1;
    w_in   = 16'h2222;
    send(16'h1111, 1'b0, 16'd0, 1'b0, 1'b0);
    w_load = 1'b0;
    send(16'h1111, 1'b0, 16'd0, 1'b0, 1'b0);
    idle(5);
    e = '{16'd4, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    check_log("t6_wswitch", 2, e);

    // reset with two beats in flight
    log_q.delete();
    out_ready = 1'b0;
    send(16'h1111, 1'b0, 16'd5, 1'b0, 1'b0);
    send(16'h1111, 1'b0, 16'd6, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t6_flush_valid", 32'(out_valid), 32'(0));
      check("t6_flush_out", 32'(out), 32'(0));
    end
    tick();
    check("t6_flush_none", 32'(log_q.size()), 32'(0));

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a_in      = 16'($urandom);
      a_signed  = 1'($urandom_range(0, 1));
      c_in      = 16'($urandom);
      acc_mode  = 1'($urandom_range(0, 1));
      acc_first = ($urandom_range(0, 3) == 0);
      w_load    = ($urandom_range(0, 15) == 0);
      w_in      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset     = 1'b0;
    w_load    = 1'b0;
    out_ready = 1'b1;
    idle(8);
    check("drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
